bit_deserializer: RTL and testbench
===================================

// Module: bit_deserializer
// PURPOSE
//   Bit-serial receiver that assembles a stream of single bits into C_WIDTH-bit words.
//   Words are presented on a valid/ready output port.
//   Sits at the far end of bit-wide delay/serial paths: a producer shifts bits out with ce; this block collects them.
//   Detects framing restarts and output overflow.
// PARAMETERS
//   C_WIDTH      8  word width in bits; legal range 2..64
//   C_MSB_FIRST  1  1: first received bit lands in data_out[C_WIDTH-1]; 0: first bit lands in data_out[0]
// PORTS
//   clk          in   1        clock; all logic on the rising edge
//   rst          in   1        reset, asynchronous, active-high
//   ce           in   1        bit strobe; data_in and frame_start are sampled only when ce=1
//   data_in      in   1        serial data bit
//   frame_start  in   1        qualified by ce; marks the current data_in as bit 0 of a word
//   data_out     out  C_WIDTH  assembled word
//   data_valid   out  1        data_out holds an unconsumed word
//   data_ready   in   1        consumer accepts the word when data_valid=1 and data_ready=1
//   sync_err     out  1        1-cycle pulse: frame_start arrived mid-word, partial word discarded
//   overflow     out  1        1-cycle pulse: word completed while the output was full; new word dropped
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - Outputs: data_out=0, data_valid=0, sync_err=0, overflow=0.
//     - Internal: shift register=0, bit_cnt=0, FSM=IDLE.
//     - Reset mid-word or mid-handshake discards everything; no pulse is generated.
//   FSM
//     - IDLE: ce=0, or ce=1 with frame_start=0 -> stay in IDLE, bit ignored.
//       ce=1 with frame_start=1 -> accept bit as bit 0, bit_cnt=1, go to RECV.
//     - RECV: each ce=1 cycle accepts one bit and increments bit_cnt.
//       The bit that makes bit_cnt reach C_WIDTH completes the word; bit_cnt then wraps to 0.
//       FSM stays in RECV (continuous mode), so the next ce bit starts a new word without frame_start.
//     - RECV, ce=1, frame_start=1, bit_cnt!=0: discard partial word, load this bit as bit 0, bit_cnt=1.
//       sync_err=1 on the following cycle.
//     - RECV, ce=1, frame_start=1, bit_cnt==0: normal word start; no sync_err.
//     - ce=0: shift path, bit_cnt and FSM hold; the output handshake still operates.
//   Word completion (same edge as the last bit is accepted)
//     - The full word, including the last bit, moves directly to the output register.
//       data_valid=1 in the cycle after that edge, so latency from last bit sampled to valid is 1 clk.
//     - Output empty, or data_valid=1 with data_ready=1 in the same cycle: load the new word; data_valid=1.
//     - data_valid=1 with data_ready=0: keep the old data_out, drop the new word, overflow=1 next cycle.
//   Output handshake
//     - data_out and data_valid stay stable while data_valid=1 and data_ready=0.
//     - A transfer with no simultaneous completion clears data_valid on the next cycle.
//     - data_ready is ignored while data_valid=0.
//   Bit order
//     - C_MSB_FIRST=1: shift left, new bit into LSB; first bit ends in data_out[C_WIDTH-1].
//     - C_MSB_FIRST=0: shift right, new bit into MSB; first bit ends in data_out[0].
//   Pulses
//     - sync_err and overflow are registered and last exactly one cycle per event.
//     - Both may assert in the same cycle.
// TESTING  (C_WIDTH=8 unless noted)
//   1. Reset mid-word: rst asserted asynchronously between edges ->
//      outputs clear immediately; after release, bits without frame_start are ignored.
//   2. MSB-first: ce=1 every cycle, frame_start on bit 0, bits 1,0,1,0,0,1,0,1, data_ready=1 ->
//      data_out=8'hA5 with data_valid=1 exactly 1 clk after the 8th bit; valid drops the next cycle.
//   3. LSB-first (C_MSB_FIRST=0): same bit sequence -> data_out=8'hA5 bit-reversed = 8'hA5.
//      Then send 1,1,0,0,0,0,0,0 -> 8'h03.
//   4. Gapped ce: ce high only every 3rd cycle, words 8'h3C then 8'hF0 back-to-back with no frame_start on word 2
//      -> both delivered in order; state holds during ce=0.
//   5. Resync: frame_start at bit 5, then 8 bits of 8'h81 -> sync_err pulses once; only 8'h81 delivered.
//   6. Overflow: data_ready=0 while two words complete (8'h11, 8'h22) -> data_out stays 8'h11, overflow pulses once.
//      Then ready=1 with a third word completing the same cycle -> 8'h11 is taken, data_out=8'h33, data_valid stays 1.

Source files
------------

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: collects ce-qualified bits into C_WIDTH-bit words and
// presents them on a valid/ready port, flagging mid-word resyncs and dropped words.
module bit_deserializer #(
   parameter int C_WIDTH     = 8,
   parameter bit C_MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               data_in,
   input  logic               frame_start,
   output logic [C_WIDTH-1:0] data_out,
   output logic               data_valid,
   input  logic               data_ready,
   output logic               sync_err,
   output logic               overflow
);

   localparam int CNT_W = $clog2(C_WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [C_WIDTH-1:0] shift_reg, shift_nxt, shift_base, word;
   logic [CNT_W-1:0]   bit_cnt, cnt_nxt, cnt_base, cnt_inc;
   logic [C_WIDTH-1:0] data_out_nxt;
   logic               data_valid_nxt, sync_err_nxt, overflow_nxt;
   logic               restart, accept, complete;

   always_comb begin
      state_nxt      = state;
      shift_nxt      = shift_reg;
      cnt_nxt        = bit_cnt;
      shift_base     = shift_reg;
      cnt_base       = bit_cnt;
      data_out_nxt   = data_out;
      data_valid_nxt = data_valid;
      restart        = ce && frame_start;
      accept         = ce && ((state == RECV) || frame_start);

      // A qualified frame_start always restarts the word from an empty shifter
      if (restart) begin
         shift_base = '0;
         cnt_base   = '0;
      end
      word     = C_MSB_FIRST ? {shift_base[C_WIDTH-2:0], data_in}
                             : {data_in, shift_base[C_WIDTH-1:1]};
      cnt_inc  = cnt_base + 1'b1;
      complete = accept && (cnt_inc == CNT_W'(C_WIDTH));

      if (accept) begin
         state_nxt = RECV;
         shift_nxt = word;
         cnt_nxt   = complete ? '0 : cnt_inc;
      end

      sync_err_nxt = restart && (state == RECV) && (bit_cnt != '0);
      overflow_nxt = complete && data_valid && !data_ready;

      // The completed word bypasses the shifter so valid follows the last bit by one clock
      if (complete && (!data_valid || data_ready)) begin
         data_out_nxt   = word;
         data_valid_nxt = 1'b1;
      end else if (data_valid && data_ready) begin
         data_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sync_err   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift_reg  <= shift_nxt;
         bit_cnt    <= cnt_nxt;
         data_out   <= data_out_nxt;
         data_valid <= data_valid_nxt;
         sync_err   <= sync_err_nxt;
         overflow   <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share one bit stream;
// expected words are queued by the stimulus and popped by a monitor on each transfer.
module tb_bit_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic       data_in = 1'b0;
   logic       frame_start = 1'b0;
   logic       data_ready = 1'b1;
   logic [7:0] dout_m, dout_l;
   logic       vld_m, vld_l, serr_m, serr_l, ovf_m, ovf_l;

   int         n_checks = 0;
   int         n_pass = 0;
   int         sync_cnt_m = 0, sync_cnt_l = 0, ovf_cnt_m = 0, ovf_cnt_l = 0;
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];

   always #5 clk = ~clk;

   bit_deserializer #(.C_WIDTH(8), .C_MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .frame_start(frame_start),
      .data_out(dout_m), .data_valid(vld_m), .data_ready(data_ready),
      .sync_err(serr_m), .overflow(ovf_m));

   bit_deserializer #(.C_WIDTH(8), .C_MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .frame_start(frame_start),
      .data_out(dout_l), .data_valid(vld_l), .data_ready(data_ready),
      .sync_err(serr_l), .overflow(ovf_l));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input logic [7:0] m, input logic [7:0] l);
      q_m.push_back(m);
      q_l.push_back(l);
   endtask

   task automatic send_bit(input logic b, input logic fs);
      ce = 1'b1;
      data_in = b;
      frame_start = fs;
      @(posedge clk);
      #1;
      ce = 1'b0;
      frame_start = 1'b0;
   endtask

   // ce low cycles with noisy data/frame_start that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ce = 1'b0;
         data_in = ~data_in;
         frame_start = 1'b1;
         @(posedge clk);
         #1;
      end
      frame_start = 1'b0;
   endtask

   // sends the top n bits of v, MSB of v first
   task automatic send_bits(input logic [7:0] v, input int n, input logic fs, input int gap);
      for (int i = 0; i < n; i++) begin
         send_bit(v[7-i], fs && (i == 0));
         if (gap > 0) idle(gap);
      end
   endtask

   // monitor: pops and compares on every transfer, counts pulse cycles
   always @(negedge clk) begin
      if (!rst) begin
         if (vld_m && data_ready) begin
            if (q_m.size() == 0) check("msb_unexpected_word", {56'd0, dout_m}, 64'hDEAD);
            else check("msb_word", {56'd0, dout_m}, {56'd0, q_m.pop_front()});
         end
         if (vld_l && data_ready) begin
            if (q_l.size() == 0) check("lsb_unexpected_word", {56'd0, dout_l}, 64'hDEAD);
            else check("lsb_word", {56'd0, dout_l}, {56'd0, q_l.pop_front()});
         end
         if (serr_m) sync_cnt_m++;
         if (serr_l) sync_cnt_l++;
         if (ovf_m) ovf_cnt_m++;
         if (ovf_l) ovf_cnt_l++;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      check("reset_data_out", {56'd0, dout_m}, 64'd0);
      check("reset_valid", {62'd0, vld_m, vld_l}, 64'd0);
      check("reset_pulses", {60'd0, serr_m, serr_l, ovf_m, ovf_l}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // reset mid-word while a word is held unconsumed
      data_ready = 1'b0;
      send_bits(8'h55, 8, 1'b1, 0);
      check("pre_reset_valid", {63'd0, vld_m}, 64'd1);
      send_bits(8'hE0, 3, 1'b0, 0);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_valid", {62'd0, vld_m, vld_l}, 64'd0);
      check("async_reset_data", {48'd0, dout_m, dout_l}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      data_ready = 1'b1;
      send_bits(8'hFF, 8, 1'b0, 0);
      check("no_frame_ignored", {62'd0, vld_m, vld_l}, 64'd0);

      // MSB-first A5 with back-to-back ce; latency exactly one clock
      push(8'hA5, 8'hA5);
      send_bits(8'hA5, 7, 1'b1, 0);
      check("a5_not_early", {62'd0, vld_m, vld_l}, 64'd0);
      send_bit(1'b1, 1'b0);
      check("a5_valid_latency", {62'd0, vld_m, vld_l}, 64'd3);
      check("a5_data_msb", {56'd0, dout_m}, 64'hA5);
      check("a5_data_lsb", {56'd0, dout_l}, 64'hA5);
      idle(1);
      check("a5_valid_drop", {62'd0, vld_m, vld_l}, 64'd0);

      // 1,1,0,0,0,0,0,0 with frame_start at a word boundary
      push(8'hC0, 8'h03);
      send_bits(8'hC0, 8, 1'b1, 0);
      idle(1);

      // gapped ce, second word continues without frame_start
      push(8'h3C, 8'h3C);
      push(8'hF0, 8'h0F);
      send_bits(8'h3C, 8, 1'b1, 2);
      send_bits(8'hF0, 8, 1'b0, 2);
      idle(1);

      // resync after 5 bits of a partial word
      push(8'h81, 8'h81);
      send_bits(8'hFF, 5, 1'b1, 0);
      send_bits(8'h81, 8, 1'b1, 0);
      idle(1);

      // overflow: second word dropped while the first is stalled
      data_ready = 1'b0;
      push(8'h11, 8'h88);
      send_bits(8'h11, 8, 1'b1, 0);
      send_bits(8'h22, 8, 1'b0, 0);
      idle(1);
      check("ovf_hold_msb", {55'd0, vld_m, dout_m}, {55'd0, 1'b1, 8'h11});
      check("ovf_hold_lsb", {55'd0, vld_l, dout_l}, {55'd0, 1'b1, 8'h88});
      push(8'h33, 8'hCC);
      send_bits(8'h33, 7, 1'b0, 0);
      data_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      check("take_and_load_msb", {55'd0, vld_m, dout_m}, {55'd0, 1'b1, 8'h33});
      check("take_and_load_lsb", {55'd0, vld_l, dout_l}, {55'd0, 1'b1, 8'hCC});
      idle(4);

      check("queue_msb_empty", 64'(q_m.size()), 64'd0);
      check("queue_lsb_empty", 64'(q_l.size()), 64'd0);
      check("sync_err_count", {32'(sync_cnt_m), 32'(sync_cnt_l)}, {32'd1, 32'd1});
      check("overflow_count", {32'(ovf_cnt_m), 32'(ovf_cnt_l)}, {32'd1, 32'd1});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
